// File: rtl/tile_load_sched_if.sv
// Load handshake between tile_load_sched (master) and tile_loader / bram_pingpong (slave).
interface tile_load_sched_if;
   logic        ld_req;
   logic        update_A;
   logic [31:0] j_block;
   logic        ld_done;
   logic        b_bank_free;

   modport master (output ld_req, update_A, j_block, input ld_done, b_bank_free);
   modport slave  (input ld_req, update_A, j_block, output ld_done, b_bank_free);
endinterface

// File: rtl/tile_load_sched.sv
// Sequences tile_loader over one output row-panel: optional A load, then a sweep of B blocks,
// each B load gated on a free ping-pong bank, with a completion watchdog.
module tile_load_sched #(
   parameter int TMO_W = 16,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic              load_A_en,
   input  logic [31:0]       K,
   input  logic [31:0]       M,
   input  logic [31:0]       BLOCK_M_CFG,
   tile_load_sched_if.master ld,
   output logic [CNT_W-1:0]  blk_idx,
   output logic [CNT_W-1:0]  blocks_total,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              tmo_err
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_CHECK     = 4'd1;
   localparam logic [3:0] S_REQ_A     = 4'd2;
   localparam logic [3:0] S_WAIT_A    = 4'd3;
   localparam logic [3:0] S_WAIT_BANK = 4'd4;
   localparam logic [3:0] S_REQ_B     = 4'd5;
   localparam logic [3:0] S_WAIT_B    = 4'd6;
   localparam logic [3:0] S_NEXT      = 4'd7;
   localparam logic [3:0] S_FIN       = 4'd8;

   // The request cycle counts as 1, so expiry lands done exactly 2**TMO_W-1 cycles after ld_req.
   localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] IDX_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       state_q, state_d;
   logic [31:0]      k_q, k_d, m_q, m_d, bm_q, bm_d;
   logic             load_a_q, load_a_d;
   logic             update_a_q, update_a_d;
   logic             abort_seen_q, abort_seen_d;
   logic             cfg_err_q, cfg_err_d;
   logic             tmo_err_q, tmo_err_d;
   logic [32:0]      j_block_q, j_block_d;
   logic [CNT_W-1:0] blk_idx_q, blk_idx_d;
   logic [CNT_W-1:0] blocks_total_q, blocks_total_d;
   logic [TMO_W-1:0] wdog_q, wdog_d;

   logic [32:0]      span;
   logic [32:0]      quot;
   logic             unused_quot_hi;
   logic             cfg_bad;
   logic             abort_any;
   logic             last_blk;

   assign span           = {1'b0, m_q} + {1'b0, bm_q} - 33'd1;
   assign quot           = (bm_q == 32'd0) ? 33'd0 : span / {1'b0, bm_q};
   assign unused_quot_hi = ^quot[32:CNT_W];
   assign cfg_bad        = (k_q == 32'd0) || (m_q == 32'd0) || (bm_q == 32'd0);
   assign abort_any      = abort_seen_q | abort;
   assign last_blk       = ({1'b0, blk_idx_q} + {1'b0, IDX_ONE}) == {1'b0, blocks_total_q};

   always_comb begin
      state_d        = state_q;
      k_d            = k_q;
      m_d            = m_q;
      bm_d           = bm_q;
      load_a_d       = load_a_q;
      update_a_d     = update_a_q;
      abort_seen_d   = abort_seen_q;
      cfg_err_d      = cfg_err_q;
      tmo_err_d      = tmo_err_q;
      j_block_d      = j_block_q;
      blk_idx_d      = blk_idx_q;
      blocks_total_d = blocks_total_q;
      wdog_d         = wdog_q;

      if (state_q != S_IDLE && abort) begin
         abort_seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d            = K;
               m_d            = M;
               bm_d           = BLOCK_M_CFG;
               load_a_d       = load_A_en;
               update_a_d     = 1'b0;
               abort_seen_d   = 1'b0;
               cfg_err_d      = 1'b0;
               tmo_err_d      = 1'b0;
               j_block_d      = 33'd0;
               blk_idx_d      = '0;
               blocks_total_d = '0;
               state_d        = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cfg_bad) begin
               cfg_err_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               blocks_total_d = quot[CNT_W-1:0];
               if (load_a_q) begin
                  update_a_d = 1'b1;
                  state_d    = S_REQ_A;
               end else begin
                  state_d = S_WAIT_BANK;
               end
            end
         end
         S_REQ_A: begin
            wdog_d  = WDOG_ONE;
            state_d = S_WAIT_A;
         end
         S_WAIT_A: begin
            if (ld.ld_done) begin
               update_a_d = 1'b0;
               state_d    = abort_any ? S_FIN : S_WAIT_BANK;
            end else if (wdog_q == WDOG_LAST) begin
               tmo_err_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               wdog_d = wdog_q + WDOG_ONE;
            end
         end
         S_WAIT_BANK: begin
            if (abort_any) begin
               state_d = S_FIN;
            end else if (ld.b_bank_free) begin
               state_d = S_REQ_B;
            end
         end
         S_REQ_B: begin
            wdog_d  = WDOG_ONE;
            state_d = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (ld.ld_done) begin
               state_d = S_NEXT;
            end else if (wdog_q == WDOG_LAST) begin
               tmo_err_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               wdog_d = wdog_q + WDOG_ONE;
            end
         end
         S_NEXT: begin
            if (abort_any || last_blk) begin
               state_d = S_FIN;
            end else begin
               blk_idx_d = blk_idx_q + IDX_ONE;
               j_block_d = j_block_q + {1'b0, bm_q};
               state_d   = S_WAIT_BANK;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         k_q            <= '0;
         m_q            <= '0;
         bm_q           <= '0;
         load_a_q       <= 1'b0;
         update_a_q     <= 1'b0;
         abort_seen_q   <= 1'b0;
         cfg_err_q      <= 1'b0;
         tmo_err_q      <= 1'b0;
         j_block_q      <= '0;
         blk_idx_q      <= '0;
         blocks_total_q <= '0;
         wdog_q         <= '0;
      end else begin
         state_q        <= state_d;
         k_q            <= k_d;
         m_q            <= m_d;
         bm_q           <= bm_d;
         load_a_q       <= load_a_d;
         update_a_q     <= update_a_d;
         abort_seen_q   <= abort_seen_d;
         cfg_err_q      <= cfg_err_d;
         tmo_err_q      <= tmo_err_d;
         j_block_q      <= j_block_d;
         blk_idx_q      <= blk_idx_d;
         blocks_total_q <= blocks_total_d;
         wdog_q         <= wdog_d;
      end
   end

   assign ld.ld_req     = (state_q == S_REQ_A) || (state_q == S_REQ_B);
   assign ld.update_A   = update_a_q;
   assign ld.j_block    = j_block_q[31:0];
   assign blk_idx       = blk_idx_q;
   assign blocks_total  = blocks_total_q;
   assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done          = (state_q == S_FIN);
   assign cfg_err       = cfg_err_q;
   assign tmo_err       = tmo_err_q;

endmodule

// File: tb/tb_tile_load_sched.sv
// Scoreboard bench for tile_load_sched: a reference model queues expected loads and completions,
// a negedge monitor pops and compares them; a loader stub and a bank driver close the loop.
module tb_tile_load_sched;

   localparam int TMO_W  = 4;
   localparam int CNT_W  = 16;
   localparam int NO_LIM = 1 << 30;

   typedef struct {
      bit          upd;
      logic [31:0] j;
   } req_t;

   typedef struct {
      bit          cfg;
      bit          tmo;
      bit          chk;
      int unsigned total;
      int unsigned idx;
   } done_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic             abort;
   logic             load_a_en;
   logic [31:0]      k_cfg;
   logic [31:0]      m_cfg;
   logic [31:0]      bm_cfg;
   logic [CNT_W-1:0] blk_idx;
   logic [CNT_W-1:0] blocks_total;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic             tmo_err;

   tile_load_sched_if ld_if ();

   tile_load_sched #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .abort        (abort),
      .load_A_en    (load_a_en),
      .K            (k_cfg),
      .M            (m_cfg),
      .BLOCK_M_CFG  (bm_cfg),
      .ld           (ld_if),
      .blk_idx      (blk_idx),
      .blocks_total (blocks_total),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err),
      .tmo_err      (tmo_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   req_t  exp_req[$];
   done_t exp_done[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Loader stub: answers each request after stub_lat cycles (-1 = random 1..10, 0 = never).
   int stub_lat = 5;
   int stub_cd  = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         stub_cd = 0;
      end else if (ld_if.ld_req) begin
         if (stub_lat > 0)      stub_cd = stub_lat;
         else if (stub_lat < 0) stub_cd = $urandom_range(1, 10);
         else                   stub_cd = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      ld_if.ld_done = 1'b0;
      if (stub_cd > 0) begin
         stub_cd--;
         if (stub_cd == 0) ld_if.ld_done = 1'b1;
      end
   end

   // Bank driver: 0 = always free, 1 = random, 2 = held busy.
   int   bank_mode     = 0;
   int   bank_rise_cyc = -1;
   logic bank_nxt;

   always @(posedge clk) begin
      #2;
      case (bank_mode)
         0:       bank_nxt = 1'b1;
         1:       bank_nxt = ($urandom_range(0, 2) != 0);
         default: bank_nxt = 1'b0;
      endcase
      if (bank_nxt && !ld_if.b_bank_free) bank_rise_cyc = cyc;
      ld_if.b_bank_free = bank_nxt;
   end

   int          req_count        = 0;
   int          done_count       = 0;
   int          first_req_cyc    = -1;
   int          last_req_cyc     = -1;
   int          last_done_in_cyc = -100;
   int          done_cyc         = -1;
   int          start_cyc        = 0;
   bit          outstanding      = 1'b0;
   bit          held_upd;
   logic [31:0] held_j;
   req_t        mon_req;
   done_t       mon_done;

   always @(negedge clk) begin
      if (!rstn) begin
         outstanding = 1'b0;
      end else begin
         if (ld_if.ld_done && outstanding) begin
            check_output("update_A_stable", ld_if.update_A, held_upd);
            check_output("j_block_stable", ld_if.j_block, held_j);
            outstanding      = 1'b0;
            last_done_in_cyc = cyc;
         end
         if (ld_if.ld_req) begin
            check_output("req_gap_after_done", (cyc - last_done_in_cyc) >= 2, 1);
            req_count++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (exp_req.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_ld_req: got update_A=%0d j_block=%0h, expected none", ld_if.update_A, ld_if.j_block);
            end else begin
               mon_req = exp_req.pop_front();
               check_output("update_A", ld_if.update_A, mon_req.upd);
               check_output("j_block", ld_if.j_block, mon_req.j);
            end
            held_upd    = ld_if.update_A;
            held_j      = ld_if.j_block;
            outstanding = 1'b1;
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            check_output("busy_low_at_done", busy, 0);
            if (exp_done.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_done: got done=1, expected none");
            end else begin
               mon_done = exp_done.pop_front();
               check_output("cfg_err", cfg_err, mon_done.cfg);
               check_output("tmo_err", tmo_err, mon_done.tmo);
               if (mon_done.chk) begin
                  check_output("blocks_total", blocks_total, mon_done.total);
                  check_output("blk_idx", blk_idx, mon_done.idx);
               end
            end
         end
      end
   end

   // Reference model: walk j = 0, bm, 2*bm, ... while j < m; limit models an abort cut-off.
   task automatic build_expect(input bit la, input logic [31:0] k, input logic [31:0] m,
                               input logic [31:0] bm, input int limit, input bit tmo);
      longint unsigned j;
      int              nb;
      req_t            r;
      done_t           d;
      if (k == 0 || m == 0 || bm == 0) begin
         d = '{1'b1, 1'b0, 1'b0, 0, 0};
         exp_done.push_back(d);
         return;
      end
      if (la) begin
         r = '{1'b1, 32'd0};
         exp_req.push_back(r);
      end
      nb = 0;
      j  = 0;
      while (j < {32'd0, m}) begin
         if (!tmo && nb < limit) begin
            r = '{1'b0, j[31:0]};
            exp_req.push_back(r);
         end
         nb++;
         j += {32'd0, bm};
      end
      if (tmo) d = '{1'b0, 1'b1, 1'b1, nb, 0};
      else     d = '{1'b0, 1'b0, 1'b1, nb, ((nb < limit) ? nb : limit) - 1};
      exp_done.push_back(d);
   endtask

   task automatic apply_stimulus(input bit la, input logic [31:0] k, input logic [31:0] m,
                                 input logic [31:0] bm, input int limit, input bit tmo,
                                 input bit do_model);
      if (do_model) build_expect(la, k, m, bm, limit, tmo);
      @(posedge clk); #1;
      load_a_en     = la;
      k_cfg         = k;
      m_cfg         = m;
      bm_cfg        = bm;
      start         = 1'b1;
      start_cyc     = cyc;
      first_req_cyc = -1;
      @(posedge clk); #1;
      start = 1'b0;
      check_output("busy_after_start", busy, 1);
      check_output("cfg_err_cleared", cfg_err, 0);
      check_output("tmo_err_cleared", tmo_err, 0);
   endtask

   task automatic wait_done(input int prev, input int budget);
      int n = 0;
      while (done_count == prev && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("done_seen", done_count - prev, 1);
      check_output("req_queue_drained", exp_req.size(), 0);
   endtask

   task automatic wait_reqs(input int target, input int budget);
      int n = 0;
      while (req_count < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("req_count_reached", req_count >= target, 1);
   endtask

   initial begin
      int          prev;
      int          rc0;
      bit          la;
      logic [31:0] rm;
      logic [31:0] rbm;
      logic [31:0] bad_k[3];
      logic [31:0] bad_m[3];
      logic [31:0] bad_bm[3];

      rstn      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      load_a_en = 1'b0;
      k_cfg     = '0;
      m_cfg     = '0;
      bm_cfg    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_ld_req", ld_if.ld_req, 0);
      check_output("rst_update_A", ld_if.update_A, 0);
      check_output("rst_j_block", ld_if.j_block, 0);
      check_output("rst_blk_idx", blk_idx, 0);
      check_output("rst_blocks_total", blocks_total, 0);
      check_output("rst_cfg_err", cfg_err, 0);
      check_output("rst_tmo_err", tmo_err, 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // A load then a single B block; full timeline is fixed with a 5-cycle loader.
      stub_lat  = 5;
      bank_mode = 0;
      prev      = done_count;
      apply_stimulus(1'b1, 32'd16, 32'd16, 32'd16, NO_LIM, 1'b0, 1'b1);
      wait_done(prev, 200);
      check_output("t1_first_req_latency", first_req_cyc - start_cyc, 2);
      check_output("t1_done_latency", done_cyc - start_cyc, 16);
      check_output("t1_blocks_total_held", blocks_total, 1);

      // Twelve B blocks with random loader latency and bank; a start mid-run is ignored.
      stub_lat  = -1;
      bank_mode = 1;
      prev      = done_count;
      apply_stimulus(1'b0, 32'd768, 32'd3072, 32'd256, NO_LIM, 1'b0, 1'b1);
      wait_reqs(req_count + 3, 500);
      @(posedge clk); #1;
      start     = 1'b1;
      load_a_en = 1'b1;
      m_cfg     = 32'd16;
      bm_cfg    = 32'd16;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(prev, 5000);
      check_output("t2_blk_idx_final", blk_idx, 11);

      // Tail block.
      prev = done_count;
      apply_stimulus(1'b1, 32'd8, 32'd100, 32'd32, NO_LIM, 1'b0, 1'b1);
      wait_done(prev, 2000);

      // Bad configurations: done two cycles after start, no requests, sticky error.
      bad_k  = '{32'd5, 32'd5, 32'd0};
      bad_m  = '{32'd64, 32'd0, 32'd64};
      bad_bm = '{32'd0, 32'd16, 32'd16};
      for (int i = 0; i < 3; i++) begin
         prev = done_count;
         rc0  = req_count;
         apply_stimulus(1'b1, bad_k[i], bad_m[i], bad_bm[i], NO_LIM, 1'b0, 1'b1);
         wait_done(prev, 50);
         check_output("t4_done_latency", done_cyc - start_cyc, 2);
         check_output("t4_no_ld_req", req_count - rc0, 0);
         repeat (3) @(posedge clk);
         #1;
         check_output("t4_cfg_err_sticky", cfg_err, 1);
      end

      // Bank held busy for 50 cycles after block 0.
      stub_lat  = 5;
      bank_mode = 0;
      prev      = done_count;
      apply_stimulus(1'b0, 32'd1, 32'd64, 32'd16, NO_LIM, 1'b0, 1'b1);
      wait_reqs(req_count + 1, 100);
      bank_mode = 2;
      rc0       = req_count;
      repeat (50) @(posedge clk);
      #1;
      check_output("t5_no_req_during_hold", req_count - rc0, 0);
      bank_mode = 0;
      wait_reqs(rc0 + 1, 100);
      check_output("t5_req_after_free", last_req_cyc - bank_rise_cyc, 1);
      wait_done(prev, 500);

      // Abort while block 2 is outstanding.
      stub_lat = 6;
      prev     = done_count;
      apply_stimulus(1'b0, 32'd1, 32'd128, 32'd16, 3, 1'b0, 1'b1);
      wait_reqs(req_count + 3, 200);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(prev, 200);
      check_output("t6_abort_done_latency", done_cyc - last_done_in_cyc, 2);

      // Loader never answers: watchdog expires.
      stub_lat = 0;
      prev     = done_count;
      apply_stimulus(1'b1, 32'd1, 32'd64, 32'd16, NO_LIM, 1'b1, 1'b1);
      wait_done(prev, 100);
      check_output("t6_tmo_done_latency", done_cyc - last_req_cyc, 15);
      @(posedge clk); #1;
      check_output("t6_tmo_err_sticky", tmo_err, 1);

      // Dimensions near 2^32.
      stub_lat = -1;
      prev     = done_count;
      apply_stimulus(1'b0, 32'd3, 32'hFFFF_FFF0, 32'h8000_0000, NO_LIM, 1'b0, 1'b1);
      wait_done(prev, 200);
      prev = done_count;
      apply_stimulus(1'b1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NO_LIM, 1'b0, 1'b1);
      wait_done(prev, 200);

      // Randomized configurations.
      bank_mode = 1;
      for (int i = 0; i < 8; i++) begin
         la   = 1'($urandom_range(0, 1));
         rm   = $urandom_range(1, 300);
         rbm  = $urandom_range(1, 40);
         prev = done_count;
         apply_stimulus(la, $urandom_range(1, 1000), rm, rbm, NO_LIM, 1'b0, 1'b1);
         wait_done(prev, 20000);
      end

      // Reset during an outstanding A load: sequence abandoned, no done.
      stub_lat  = 8;
      bank_mode = 0;
      exp_req.push_back('{1'b1, 32'd0});
      prev = done_count;
      apply_stimulus(1'b1, 32'd4, 32'd64, 32'd16, NO_LIM, 1'b0, 1'b0);
      wait_reqs(req_count + 1, 50);
      rstn = 1'b0;
      @(posedge clk); #1;
      check_output("midrst_busy", busy, 0);
      check_output("midrst_update_A", ld_if.update_A, 0);
      check_output("midrst_ld_req", ld_if.ld_req, 0);
      rstn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_output("midrst_no_done", done_count - prev, 0);
      check_output("midrst_req_queue", exp_req.size(), 0);
      check_output("midrst_done_queue", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
